// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 encodings,
// FSM state encodings, iteration count and small operand helpers.
package muldiv_unit_pkg;

    localparam int ITER_COUNT = 32;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic signed_a(input logic [2:0] f);
        case (f)
            MD_MULH, MD_MULHSU, MD_DIV, MD_REM: signed_a = 1'b1;
            default:                            signed_a = 1'b0;
        endcase
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic signed_b(input logic [2:0] f);
        case (f)
            MD_MULH, MD_DIV, MD_REM: signed_b = 1'b1;
            default:                 signed_b = 1'b0;
        endcase
    endfunction

    // two's complement negation, modulo 2^32
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1, rs2,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes
// at start, 32 shift-add / restoring shift-subtract steps run one per cycle,
// and the sign fixup plus special cases are applied in a single FIX cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);

    logic [1:0]      state_q,  state_d;
    logic [4:0]      cnt_q,    cnt_d;
    logic [2:0]      op_q,     op_d;
    logic            neg_q,    neg_d;     // result sign: operand signs differ
    logic            sa_q,     sa_d;      // dividend sign, for remainder
    logic            dz_q,     dz_d;      // divisor was zero
    logic [XLEN-1:0] opnd_q,   opnd_d;    // |rs1| for multiply, |rs2| for divide
    logic [XLEN-1:0] hi_q,     hi_d;      // product high half / partial remainder
    logic [XLEN-1:0] lo_q,     lo_d;      // multiplier|product low / quotient
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;

    logic            sa_s, sb_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s;
    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   diff_s;
    logic [63:0]     prod_s, prod_neg_s;

    // next-state, iteration datapath and result fixup
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        sa_d       = sa_q;
        dz_d       = dz_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        result_d   = result_q;
        done_d     = 1'b0;
        sa_s       = signed_a(bus.funct3) & bus.rs1[31];
        sb_s       = signed_b(bus.funct3) & bus.rs2[31];
        a_mag_s    = sa_s ? neg32(bus.rs1) : bus.rs1;
        b_mag_s    = sb_s ? neg32(bus.rs2) : bus.rs2;
        sum_s      = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
        shifted_s  = {hi_q, lo_q[XLEN-1]};
        diff_s     = shifted_s - {1'b0, opnd_q};
        prod_s     = {hi_q, lo_q};
        prod_neg_s = ~prod_s + 64'd1;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.funct3;
                    neg_d = sa_s ^ sb_s;
                    sa_d  = sa_s;
                    dz_d  = (bus.rs2 == 32'd0);
                    hi_d  = {XLEN{1'b0}};
                    cnt_d = 5'd0;
                    if (bus.funct3[2]) begin
                        opnd_d = b_mag_s;
                        lo_d   = a_mag_s;
                    end else begin
                        opnd_d = a_mag_s;
                        lo_d   = b_mag_s;
                    end
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (op_q[2]) begin
                    // restoring divide: subtract when the shifted remainder covers the divisor
                    if (shifted_s >= {1'b0, opnd_q}) begin
                        hi_d = diff_s[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = shifted_s[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    // shift-add multiply: product shifts right through hi:lo
                    hi_d = sum_s[XLEN:1];
                    lo_d = {sum_s[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER_COUNT - 1)) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FIX: begin
                case (op_q)
                    MD_MUL:                       result_d = lo_q;
                    MD_MULH, MD_MULHSU, MD_MULHU: result_d = neg_q ? prod_neg_s[63:32] : prod_s[63:32];
                    MD_DIV, MD_DIVU:              result_d = dz_q ? 32'hFFFF_FFFF : (neg_q ? neg32(lo_q) : lo_q);
                    MD_REM, MD_REMU:              result_d = sa_q ? neg32(hi_q) : hi_q;
                    default:                      result_d = 32'd0;
                endcase
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // state and datapath registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= {XLEN{1'b0}};
            hi_q     <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            result_q <= {XLEN{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            dz_q     <= dz_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit plus back-to-back and
// mid-operation reset sequences.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    vec_t vecs [20];

    muldiv_unit_if bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // one operation with start pulsed for a single cycle; checks latency and result
    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        logic got;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.rs1    = a;
        bus.rs2    = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.rs1   = 32'hDEAD_BEEF;
        bus.rs2   = 32'h1234_5678;
        check({nm, " busy_after_start"}, {31'd0, bus.busy}, 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) got = 1'b1;
        end
        check({nm, " latency"}, lat, 32'd33);
        check({nm, " result"}, bus.result, exp);
        @(posedge clk);
        #1;
        check({nm, " busy_drop"}, {30'd0, bus.busy, bus.done}, 32'd0);
        check({nm, " result_hold"}, bus.result, exp);
    endtask

    initial begin
        int lat;
        int gap;
        logic got;
        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{"mul_7_m3",       MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{"mul_3_4",        MD_MUL,    32'd3,          32'd4,         32'd12};
        vecs[2]  = '{"mulh_min_min",   MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[3]  = '{"mulh_m1_m1",     MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4]  = '{"mulhu_max_max",  MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[5]  = '{"mulhsu_m1_2",    MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{"div_m7_2",       MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[7]  = '{"rem_m7_2",       MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[8]  = '{"div_m7_m2",      MD_DIV,    32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3};
        vecs[9]  = '{"rem_7_m2",       MD_REM,    32'd7,          32'hFFFF_FFFE, 32'd1};
        vecs[10] = '{"divu_big_2",     MD_DIVU,   32'hFFFF_FFFE,  32'd2,         32'h7FFF_FFFF};
        vecs[11] = '{"remu_7_2",       MD_REMU,   32'd7,          32'd2,         32'd1};
        vecs[12] = '{"div_5_0",        MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[13] = '{"rem_5_0",        MD_REM,    32'd5,          32'd0,         32'd5};
        vecs[14] = '{"div_m7_0",       MD_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF};
        vecs[15] = '{"rem_m7_0",       MD_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
        vecs[16] = '{"divu_5_0",       MD_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[17] = '{"remu_5_0",       MD_REMU,   32'd5,          32'd0,         32'd5};
        vecs[18] = '{"div_ovf",        MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[19] = '{"rem_ovf",        MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.rs1    = 32'd0;
        bus.rs2    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, bus.busy}, 32'd0);
        check("reset_done",   {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result,        32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // back-to-back: start held high, operands change every cycle
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = MD_MUL;
        bus.rs1    = 32'd3;
        bus.rs2    = 32'd5;
        @(posedge clk);
        #1;
        bus.rs1 = 32'd100;
        bus.rs2 = 32'd100;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) got = 1'b1;
        end
        check("b2b first latency", lat, 32'd33);
        check("b2b first result", bus.result, 32'd15);
        @(posedge clk);
        #1;
        check("b2b idle gap busy", {31'd0, bus.busy}, 32'd0);
        bus.rs1 = 32'd6;
        bus.rs2 = 32'd7;
        @(posedge clk);
        #1;
        bus.rs1 = 32'd9;
        bus.rs2 = 32'd9;
        check("b2b second accepted", {31'd0, bus.busy}, 32'd1);
        check("b2b result held", bus.result, 32'd15);
        gap = 2;
        got = 1'b0;
        while (!got && gap < 80) begin
            @(posedge clk);
            #1;
            gap++;
            if (bus.done) got = 1'b1;
        end
        bus.start = 1'b0;
        check("b2b done spacing", gap, 32'd35);
        check("b2b second result", bus.result, 32'd42);
        @(posedge clk);
        #1;
        check("b2b end idle", {31'd0, bus.busy}, 32'd0);

        // asynchronous reset ten cycles into a divide
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = MD_DIV;
        bus.rs1    = 32'd1000;
        bus.rs2    = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid busy",   {31'd0, bus.busy}, 32'd0);
        check("rst_mid done",   {31'd0, bus.done}, 32'd0);
        check("rst_mid result", bus.result,        32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("mul_after_rst", MD_MUL, 32'd3, 32'd4, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
